systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, signed operand width of A and B.
REQ-002 SHALL have parameter BITS_C, default 16, signed accumulator width of C.
REQ-003 SHALL have parameter DIM, default 8, array dimension (rows = cols).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-006 SHALL have port start, input, 1, request one DIMxDIM multiply C=A*B.
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at job end.
REQ-009 SHALL have port op_rd_en, output, 1, read strobe to the A and B operand memories.
REQ-010 SHALL have port op_rd_addr, output, $clog2(DIM), index k; memories return A column k and B row k.
REQ-011 SHALL have port a_rdata, input, DIM x BITS_AB signed, a_rdata[i]=A[i][k], valid one cycle after op_rd_en.
REQ-012 SHALL have port b_rdata, input, DIM x BITS_AB signed, b_rdata[j]=B[k][j], valid one cycle after op_rd_en.
REQ-013 SHALL have ports sa_A, sa_B (output, DIM x BITS_AB signed), sa_Cin (output, DIM x BITS_C signed), sa_en, sa_wrEn (output, 1) and sa_Crow (output, $clog2(DIM)), driving the array.
REQ-014 SHALL have port sa_Cout, input, DIM x BITS_C signed, array row selected by sa_Crow.
REQ-015 SHALL have ports c_valid (output, 1), c_ready (input, 1), c_row (output, $clog2(DIM)) and c_data (output, DIM x BITS_C signed), result row stream.

Function
REQ-016 SHALL implement FSM IDLE -> CLEAR -> COMPUTE -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE SHALL go to CLEAR when start=1; start SHALL be ignored in every other state.
REQ-018 CLEAR SHALL last DIM cycles; each cycle sa_wrEn=1, sa_en=0, sa_Cin all zero, sa_Crow = 0..DIM-1.
REQ-019 COMPUTE SHALL last 3*DIM-1 cycles with sa_en=1 every cycle; op_rd_en=1 with op_rd_addr=k only in the first DIM cycles (k=0..DIM-1).
REQ-020 The block SHALL skew operands: sa_A[i] = a_rdata[i] delayed i cycles, sa_B[j] = b_rdata[j] delayed j cycles; skew stages SHALL shift only in COMPUTE.
REQ-021 sa_A and sa_B lanes carrying no valid k SHALL be driven zero, so padding adds nothing to C.
REQ-022 DRAIN SHALL set sa_Crow=c_row, c_data=sa_Cout combinationally and c_valid=1; c_row SHALL start at 0.
REQ-023 c_row SHALL advance only on c_valid and c_ready; a handshake at c_row=DIM-1 SHALL enter DONE.
REQ-024 c_valid with c_row and c_data SHALL stay stable while c_ready=0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 Outside CLEAR, sa_wrEn SHALL be 0; outside COMPUTE, sa_en and op_rd_en SHALL be 0.
REQ-027 The block SHALL do no arithmetic on C; C overflow wraps in the array.

Reset
REQ-028 rst=1 SHALL, on the next edge and in any state including mid-job, force IDLE and clear all counters and skew stages.
REQ-029 After reset, busy, done, op_rd_en, sa_en, sa_wrEn and c_valid SHALL be 0; all data and index outputs SHALL be 0.
REQ-030 rst SHALL take priority over start on the same edge.

Structure
REQ-031 Package systolic_pkg SHALL hold the FSM state enum and default DIM, BITS_AB and BITS_C constants.
REQ-032 The per-lane delay line SHALL be sub-module skew_buffer (params WIDTH and DEPTH; DEPTH=0 is a wire), instanced once per A lane and once per B lane.

Verification
REQ-033 DIM=8, start at cycle 0, c_ready=1 -> CLEAR cycles 1-8, COMPUTE 9-31, DRAIN 32-39, done=1 only at cycle 40.
REQ-034 A=identity, B[k][j]=8k+j -> c_data row r equals 8r+j for j=0..7.
REQ-035 A=B all -128 -> every C element = 8*16384, wrapped to 16 bits = 0.
REQ-036 c_ready low for 3 cycles at c_row=2 -> c_row and c_data held, no row lost or repeated, done delayed 3 cycles.
REQ-037 rst=1 at cycle 15, then a new start -> idle outputs next cycle; second job gives correct C with no stale partial sums.
REQ-038 start held high through a whole job -> one job only; next job begins the cycle after done.

Source files
------------

// File: rtl/systolic_array_ctrl_pkg.sv
// Shared definitions for the systolic array controller.
//   state_t          : controller FSM states
//   *_DEFAULT        : default array dimension and operand/accumulator widths
package systolic_pkg;

  localparam int DIM_DEFAULT     = 8;
  localparam int BITS_AB_DEFAULT = 8;
  localparam int BITS_C_DEFAULT  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_array_ctrl_skew_buffer.sv
// Per-lane operand delay line used to skew operands into the systolic array.
//   clk, rst : clock and synchronous active-high reset (clears every stage)
//   en       : shift enable; the line holds its contents while low
//   din/dout : signed lane data in, and the same data DEPTH enabled shifts later
// DEPTH=0 degenerates to a plain wire.
module skew_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout        = din;
  end else begin : g_dly
    logic signed [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < DEPTH; s++) stage_p[s] <= '0;
      end else if (en) begin
        stage_p[0] <= din;
        for (int s = 1; s < DEPTH; s++) stage_p[s] <= stage_p[s-1];
      end
    end

    assign dout = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Controller for a DIM x DIM output-stationary systolic array computing C = A*B.
//   clk, rst, start      : clock, synchronous active-high reset, job request
//   busy, done           : not-idle flag, one-cycle end-of-job pulse
//   op_rd_en/op_rd_addr  : operand memory read (A column k, B row k)
//   a_rdata, b_rdata     : operand lanes, valid one cycle after op_rd_en
//   sa_A, sa_B           : skewed operand lanes into the array edges
//   sa_Cin/sa_wrEn       : accumulator row write (used to clear C)
//   sa_en                : array compute enable
//   sa_Crow/sa_Cout      : accumulator row select and its read data
//   c_valid/c_ready      : result row stream handshake
//   c_row/c_data         : result row index and contents
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int BITS_C  = BITS_C_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      op_rd_en,
  output logic [$clog2(DIM)-1:0]    op_rd_addr,
  input  logic signed [BITS_AB-1:0] a_rdata [DIM],
  input  logic signed [BITS_AB-1:0] b_rdata [DIM],
  output logic signed [BITS_AB-1:0] sa_A    [DIM],
  output logic signed [BITS_AB-1:0] sa_B    [DIM],
  output logic signed [BITS_C-1:0]  sa_Cin  [DIM],
  output logic                      sa_en,
  output logic                      sa_wrEn,
  output logic [$clog2(DIM)-1:0]    sa_Crow,
  input  logic signed [BITS_C-1:0]  sa_Cout [DIM],
  output logic                      c_valid,
  input  logic                      c_ready,
  output logic [$clog2(DIM)-1:0]    c_row,
  output logic signed [BITS_C-1:0]  c_data  [DIM]
);

  localparam int AW = $clog2(DIM);
  localparam int CW = $clog2(3 * DIM);
  localparam logic [CW-1:0] CLEAR_LAST   = CW'(DIM - 1);
  localparam logic [CW-1:0] COMPUTE_LAST = CW'(3 * DIM - 2);
  localparam logic [CW-1:0] READ_CYCLES  = CW'(DIM);
  localparam logic [AW-1:0] ROW_LAST     = AW'(DIM - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          rd_vld_p1;
  logic          shift_en;
  logic signed [BITS_AB-1:0] a_lane_p1 [DIM];
  logic signed [BITS_AB-1:0] b_lane_p1 [DIM];

  // State, phase counter, result row and read-valid registers.
  // cnt restarts at every state change, so it indexes cycles within a phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      c_row     <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= op_rd_en;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == CLEAR || state == COMPUTE) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DRAIN && c_ready) begin
        c_row <= (c_row == ROW_LAST) ? '0 : c_row + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    op_rd_en   = 1'b0;
    op_rd_addr = '0;
    sa_en      = 1'b0;
    sa_wrEn    = 1'b0;
    sa_Crow    = '0;
    c_valid    = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      sa_Cin[j] = '0;
      c_data[j] = '0;
    end
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        // Zero one accumulator row per cycle.
        sa_wrEn = 1'b1;
        sa_Crow = cnt[AW-1:0];
        if (cnt == CLEAR_LAST) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        // Reads occupy the first DIM cycles; the rest lets the skewed
        // wavefront reach the far corner of the array.
        sa_en = 1'b1;
        if (cnt < READ_CYCLES) begin
          op_rd_en   = 1'b1;
          op_rd_addr = cnt[AW-1:0];
        end
        if (cnt == COMPUTE_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        c_valid = 1'b1;
        sa_Crow = c_row;
        for (int j = 0; j < DIM; j++) c_data[j] = sa_Cout[j];
        if (c_ready && c_row == ROW_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: memory read data, forced to zero whenever it does not carry a
  // requested k so that padding cycles contribute nothing to C.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_lane_p1[i] = rd_vld_p1 ? a_rdata[i] : '0;
      b_lane_p1[i] = rd_vld_p1 ? b_rdata[i] : '0;
    end
  end

  assign shift_en = (state == COMPUTE);

  // Skew stages: lane n is delayed n cycles so A[i][k] meets B[k][j] in PE(i,j).
  for (genvar n = 0; n < DIM; n++) begin : g_lane
    skew_buffer #(.WIDTH(BITS_AB), .DEPTH(n)) u_skew_a (
      .clk  (clk),
      .rst  (rst),
      .en   (shift_en),
      .din  (a_lane_p1[n]),
      .dout (sa_A[n])
    );
    skew_buffer #(.WIDTH(BITS_AB), .DEPTH(n)) u_skew_b (
      .clk  (clk),
      .rst  (rst),
      .en   (shift_en),
      .din  (b_lane_p1[n]),
      .dout (sa_B[n])
    );
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: operand memories, a behavioural
// output-stationary array, and per-cycle checks against expectations derived
// from the matrix product and the phase timing.
module tb_systolic_array_ctrl;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int AW      = $clog2(DIM);

  logic clk = 1'b0;
  logic rst, start, busy, done, op_rd_en;
  logic [AW-1:0] op_rd_addr, sa_Crow, c_row;
  logic signed [BITS_AB-1:0] a_rdata [DIM];
  logic signed [BITS_AB-1:0] b_rdata [DIM];
  logic signed [BITS_AB-1:0] sa_A    [DIM];
  logic signed [BITS_AB-1:0] sa_B    [DIM];
  logic signed [BITS_C-1:0]  sa_Cin  [DIM];
  logic signed [BITS_C-1:0]  sa_Cout [DIM];
  logic signed [BITS_C-1:0]  c_data  [DIM];
  logic sa_en, sa_wrEn, c_valid, c_ready;

  int checks   = 0;
  int failures = 0;

  logic signed [BITS_AB-1:0] mA   [DIM][DIM];
  logic signed [BITS_AB-1:0] mB   [DIM][DIM];
  logic signed [BITS_C-1:0]  expC [DIM][DIM];

  // Behavioural array state
  int acc [DIM][DIM];
  logic signed [BITS_AB-1:0] hA [3*DIM][DIM];
  logic signed [BITS_AB-1:0] hB [3*DIM][DIM];
  int tcnt = 0;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .sa_A(sa_A), .sa_B(sa_B), .sa_Cin(sa_Cin),
    .sa_en(sa_en), .sa_wrEn(sa_wrEn), .sa_Crow(sa_Crow), .sa_Cout(sa_Cout),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_data(c_data)
  );

  // Operand memories: one-cycle read latency, junk on the bus when not read.
  always @(posedge clk) begin
    for (int i = 0; i < DIM; i++) begin
      a_rdata[i] <= op_rd_en ? mA[i][op_rd_addr] : BITS_AB'($urandom);
      b_rdata[i] <= op_rd_en ? mB[op_rd_addr][i] : BITS_AB'($urandom);
    end
  end

  // Array: sa_A[i] reaches PE(i,j) j cycles later, sa_B[j] reaches it i cycles later.
  function automatic int lag_a(int i, int lag);
    if (lag == 0) return int'(sa_A[i]);
    if (tcnt - lag < 0) return 0;
    return int'(hA[tcnt-lag][i]);
  endfunction

  function automatic int lag_b(int j, int lag);
    if (lag == 0) return int'(sa_B[j]);
    if (tcnt - lag < 0) return 0;
    return int'(hB[tcnt-lag][j]);
  endfunction

  always @(negedge clk) begin
    if (sa_wrEn) begin
      for (int j = 0; j < DIM; j++) acc[sa_Crow][j] <= int'(sa_Cin[j]);
      tcnt <= 0;
    end else if (sa_en && tcnt < 3*DIM) begin
      for (int i = 0; i < DIM; i++) begin
        hA[tcnt][i] <= sa_A[i];
        hB[tcnt][i] <= sa_B[i];
        for (int j = 0; j < DIM; j++) acc[i][j] <= acc[i][j] + lag_a(i, j) * lag_b(j, i);
      end
      tcnt <= tcnt + 1;
    end
  end

  always_comb begin
    for (int j = 0; j < DIM; j++) sa_Cout[j] = BITS_C'(acc[sa_Crow][j]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rd_en"}, op_rd_en, 0);
    chk({tag, " rd_addr"}, op_rd_addr, 0);
    chk({tag, " sa_en"}, sa_en, 0);
    chk({tag, " wrEn"}, sa_wrEn, 0);
    chk({tag, " Crow"}, sa_Crow, 0);
    chk({tag, " c_valid"}, c_valid, 0);
    chk({tag, " c_row"}, c_row, 0);
    for (int i = 0; i < DIM; i++) begin
      chk($sformatf("%s sa_A%0d", tag, i), sa_A[i], 0);
      chk($sformatf("%s sa_B%0d", tag, i), sa_B[i], 0);
      chk($sformatf("%s Cin%0d", tag, i), sa_Cin[i], 0);
      chk($sformatf("%s c_data%0d", tag, i), c_data[i], 0);
    end
  endtask

  // mode 0: identity x ramp, 1: all -128, 2: random
  task automatic gen_mats(input int mode);
    int s;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        case (mode)
          0: begin
            mA[i][k] = (i == k) ? BITS_AB'(1) : '0;
            mB[i][k] = BITS_AB'(8 * i + k);
          end
          1: begin
            mA[i][k] = BITS_AB'(-128);
            mB[i][k] = BITS_AB'(-128);
          end
          default: begin
            mA[i][k] = BITS_AB'($urandom);
            mB[i][k] = BITS_AB'($urandom);
          end
        endcase
      end
    end
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) s += int'(mA[i][k]) * int'(mB[k][j]);
        expC[i][j] = BITS_C'(s);
      end
    end
  endtask

  // One job, cycle 0 = cycle in which start is presented.
  task automatic run_job(input int stall_row, input int stall_len, input bit keep_start,
                         input int abort_at, input bit already_started);
    int c, row, left, k;
    bit last_hs;
    logic signed [BITS_AB-1:0] e;
    if (!already_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    c_ready = 1'b1;
    c = 0;
    for (int n = 0; n < DIM; n++) begin
      @(negedge clk);
      c++;
      if (!keep_start) start = 1'b0;
      chk($sformatf("clr%0d busy", n), busy, 1);
      chk($sformatf("clr%0d wrEn", n), sa_wrEn, 1);
      chk($sformatf("clr%0d sa_en", n), sa_en, 0);
      chk($sformatf("clr%0d rd_en", n), op_rd_en, 0);
      chk($sformatf("clr%0d Crow", n), sa_Crow, n);
      chk($sformatf("clr%0d c_valid", n), c_valid, 0);
      chk($sformatf("clr%0d done", n), done, 0);
      for (int j = 0; j < DIM; j++) chk($sformatf("clr%0d Cin%0d", n, j), sa_Cin[j], 0);
    end
    for (int t = 0; t < 3*DIM-1; t++) begin
      @(negedge clk);
      c++;
      chk($sformatf("cmp%0d sa_en", t), sa_en, 1);
      chk($sformatf("cmp%0d wrEn", t), sa_wrEn, 0);
      chk($sformatf("cmp%0d busy", t), busy, 1);
      chk($sformatf("cmp%0d done", t), done, 0);
      chk($sformatf("cmp%0d c_valid", t), c_valid, 0);
      chk($sformatf("cmp%0d rd_en", t), op_rd_en, t < DIM);
      if (t < DIM) chk($sformatf("cmp%0d rd_addr", t), op_rd_addr, t);
      for (int i = 0; i < DIM; i++) begin
        k = t - 1 - i;
        e = (k >= 0 && k < DIM) ? mA[i][k] : '0;
        chk($sformatf("skewA t%0d l%0d", t, i), sa_A[i], e);
        e = (k >= 0 && k < DIM) ? mB[k][i] : '0;
        chk($sformatf("skewB t%0d l%0d", t, i), sa_B[i], e);
      end
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort");
        return;
      end
    end
    row = 0;
    left = stall_len;
    last_hs = 1'b0;
    for (int n = 0; n < DIM + stall_len && !last_hs; n++) begin
      @(negedge clk);
      c++;
      chk($sformatf("drn%0d c_valid", n), c_valid, 1);
      chk($sformatf("drn%0d busy", n), busy, 1);
      chk($sformatf("drn%0d done", n), done, 0);
      chk($sformatf("drn%0d sa_en", n), sa_en, 0);
      chk($sformatf("drn%0d rd_en", n), op_rd_en, 0);
      chk($sformatf("drn%0d wrEn", n), sa_wrEn, 0);
      chk($sformatf("drn%0d c_row", n), c_row, row);
      chk($sformatf("drn%0d Crow", n), sa_Crow, row);
      for (int j = 0; j < DIM; j++)
        chk($sformatf("c_data r%0d c%0d", row, j), c_data[j], expC[row][j]);
      if (row == stall_row && left > 0) begin
        c_ready = 1'b0;
        left--;
      end else begin
        c_ready = 1'b1;
      end
      if (c_ready) begin
        if (row == DIM - 1) last_hs = 1'b1;
        else row++;
      end
    end
    @(negedge clk);
    c_ready = 1'b1;
    chk("done pulse", done, 1);
    chk("done busy", busy, 1);
    chk("done c_valid", c_valid, 0);
    @(negedge clk);
    chk_idle("post_done");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    c_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    start = 1'b1;
    @(negedge clk);
    chk_idle("rst_over_start");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    gen_mats(0); run_job(-1, 0, 1'b0, -1, 1'b0);
    gen_mats(1); run_job(-1, 0, 1'b0, -1, 1'b0);
    gen_mats(2); run_job(2, 3, 1'b0, -1, 1'b0);
    gen_mats(2); run_job(int'($urandom_range(0, DIM-1)), int'($urandom_range(1, 4)), 1'b0, -1, 1'b0);
    gen_mats(2); run_job(-1, 0, 1'b0, 15, 1'b0);
    gen_mats(2); run_job(-1, 0, 1'b0, -1, 1'b0);
    gen_mats(2); run_job(-1, 0, 1'b1, -1, 1'b0);
    gen_mats(2); run_job(-1, 0, 1'b0, -1, 1'b1);
    gen_mats(2); run_job(DIM-1, 2, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
